// File: rtl/enc_pkg.sv
// Shared types and constants for the encryption engine and its decrypter peer:
// FSM state enum, LFSR tap table, config limits and latch-time clamp helpers.
package enc_pkg;

    localparam int MSG_DEPTH = 64;
    localparam int ADDR_W    = $clog2(MSG_DEPTH);
    localparam int PRE_MIN   = 7;
    localparam int PRE_MAX   = 12;
    localparam int MAX_LEN   = 50;

    localparam logic [7:0] DEFAULT_PREAMBLE = 8'h7E;

    // Element 0 is the least significant slice: TAPS[0] = 5'h1E ... TAPS[5] = 5'h12.
    localparam logic [5:0][4:0] TAPS = {5'h12, 5'h14, 5'h17, 5'h1B, 5'h1D, 5'h1E};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } enc_state_e;

    function automatic logic [3:0] clamp_pre_len(input logic [7:0] v);
        if (v < 8'(PRE_MIN)) return 4'(PRE_MIN);
        if (v > 8'(PRE_MAX)) return 4'(PRE_MAX);
        return v[3:0];
    endfunction

    function automatic logic [4:0] taps_for(input logic [2:0] sel);
        return (sel > 3'd5) ? TAPS[3] : TAPS[sel];
    endfunction

    function automatic logic [4:0] clamp_seed(input logic [4:0] v);
        return (v == 5'd0) ? 5'h01 : v;
    endfunction

    function automatic logic [5:0] clamp_len(input logic [5:0] v);
        return (v > 6'(MAX_LEN)) ? 6'(MAX_LEN) : v;
    endfunction

endpackage

// File: rtl/lfsr5_step.sv
// One combinational step of the 5-bit keystream LFSR: shift left, feed back the
// parity of the tapped bits into bit 0. Shared with the decrypter.
module lfsr5_step (
    input  logic [4:0] state_i,
    input  logic [4:0] taps_i,
    output logic [4:0] next_o
);

    assign next_o = {state_i[3:0], ^(state_i & taps_i)};

endmodule

// File: rtl/encryption_engine.sv
// Buffers a plaintext message, pads it with a preamble and streams 64 LFSR-encrypted
// bytes downstream. Defining ENC_CKSUM_EN adds an XOR checksum output (cksum).
module encryption_engine
    import enc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [7:0]        preamble,
    input  logic [7:0]        pre_len,
    input  logic [2:0]        pat_sel,
    input  logic [4:0]        lfsr_seed,
    input  logic [5:0]        msg_len,
    input  logic              msg_wr_en,
    input  logic [ADDR_W-1:0] msg_waddr,
    input  logic [7:0]        msg_wdata,
    output logic              enc_valid,
    input  logic              enc_ready,
    output logic [ADDR_W-1:0] enc_addr,
    output logic [7:0]        enc_data,
    output logic              done
`ifdef ENC_CKSUM_EN
    ,
    output logic [7:0]        cksum
`endif
);

    // Handshake: a beat moves on any rising edge where enc_valid & enc_ready; while
    // enc_valid is high and enc_ready low, enc_addr/enc_data hold and the LFSR holds.

    enc_state_e        state_q;
    logic              init_q;
    logic [7:0]        buf_q [MSG_DEPTH];

    logic [3:0]        pre_len_q;
    logic [5:0]        len_q;
    logic [4:0]        taps_q;
    logic [4:0]        lfsr_q;
    logic [7:0]        preamble_q;

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic              done_q;

    logic              latch_start;
    logic [4:0]        lfsr_step_w;
    logic [ADDR_W-1:0] beat_idx;
    logic [4:0]        beat_lfsr;
    logic [6:0]        beat_rel;
    logic [7:0]        beat_plain;
    logic [7:0]        beat_byte;

    assign latch_start = (state_q == IDLE) && init_q && !init;

    lfsr5_step u_lfsr_step (
        .state_i (lfsr_q),
        .taps_i  (taps_q),
        .next_o  (lfsr_step_w)
    );

    // lfsr_q always holds s(enc_addr); the byte prepared here is for the beat that
    // follows the current one, or beat 0 when nothing is valid yet.
    always_comb begin
        beat_idx   = valid_q ? addr_q + 6'd1 : '0;
        beat_lfsr  = valid_q ? lfsr_step_w : lfsr_q;
        beat_rel   = {1'b0, beat_idx} - {3'b000, pre_len_q};
        beat_plain = preamble_q;
        if (({1'b0, beat_idx} >= {3'b000, pre_len_q}) && (beat_rel < {1'b0, len_q}))
            beat_plain = buf_q[beat_rel[ADDR_W-1:0]];
        beat_byte  = beat_plain ^ {3'b000, beat_lfsr};
    end

    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && msg_wr_en)
            buf_q[msg_waddr] <= msg_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            init_q     <= 1'b0;
            pre_len_q  <= 4'(PRE_MIN);
            len_q      <= '0;
            taps_q     <= TAPS[0];
            lfsr_q     <= 5'h01;
            preamble_q <= DEFAULT_PREAMBLE;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            init_q <= init;
            case (state_q)
                IDLE: begin
                    if (latch_start) begin
                        pre_len_q  <= clamp_pre_len(pre_len);
                        len_q      <= clamp_len(msg_len);
                        taps_q     <= taps_for(pat_sel);
                        lfsr_q     <= clamp_seed(lfsr_seed);
                        preamble_q <= preamble;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                        addr_q  <= '0;
                        data_q  <= beat_byte;
                    end else if (enc_ready) begin
                        if (addr_q == ADDR_W'(MSG_DEPTH - 1)) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            addr_q  <= beat_idx;
                            lfsr_q  <= lfsr_step_w;
                            data_q  <= beat_byte;
                        end
                    end
                end
                DONE: begin
                    if (init) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign enc_valid = valid_q;
    assign enc_addr  = addr_q;
    assign enc_data  = data_q;
    assign done      = done_q;

`ifdef ENC_CKSUM_EN
    logic [7:0] cksum_q;

    always_ff @(posedge clk) begin
        if (reset)
            cksum_q <= '0;
        else if (latch_start)
            cksum_q <= '0;
        else if (valid_q && enc_ready)
            cksum_q <= cksum_q ^ data_q;
    end

    assign cksum = cksum_q;
`endif

endmodule

// File: tb/tb_encryption_engine.sv
// Self-checking bench for encryption_engine: randomized configs, messages and
// backpressure against a frame-level reference model of the padded, encrypted stream.
module tb_encryption_engine;

    logic       clk;
    logic       reset;
    logic       init;
    logic [7:0] preamble;
    logic [7:0] pre_len;
    logic [2:0] pat_sel;
    logic [4:0] lfsr_seed;
    logic [5:0] msg_len;
    logic       msg_wr_en;
    logic [5:0] msg_waddr;
    logic [7:0] msg_wdata;
    logic       enc_valid;
    logic       enc_ready;
    logic [5:0] enc_addr;
    logic [7:0] enc_data;
    logic       done;
`ifdef ENC_CKSUM_EN
    logic [7:0] cksum;
`endif

    int vectors;
    int miscompares;

    logic [7:0] mem_m [64];
    logic [7:0] exp_q [$];
    logic [7:0] obs [64];
    int         ks [64];
    logic [7:0] exp_ck;
    int         taps_tab [6];

    string hey_msg;

    encryption_engine dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .preamble  (preamble),
        .pre_len   (pre_len),
        .pat_sel   (pat_sel),
        .lfsr_seed (lfsr_seed),
        .msg_len   (msg_len),
        .msg_wr_en (msg_wr_en),
        .msg_waddr (msg_waddr),
        .msg_wdata (msg_wdata),
        .enc_valid (enc_valid),
        .enc_ready (enc_ready),
        .enc_addr  (enc_addr),
        .enc_data  (enc_data),
        .done      (done)
`ifdef ENC_CKSUM_EN
        ,
        .cksum     (cksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level reference: clamp the raw config, then produce all 64 bytes.
    function automatic void build_expected(input int pre_raw, input int pat_raw,
                                           input int seed_raw, input int len_raw,
                                           input logic [7:0] pre_b);
        int pl, sel, s, ln, par, p;
        pl  = (pre_raw < 7) ? 7 : ((pre_raw > 12) ? 12 : pre_raw);
        sel = (pat_raw > 5) ? 3 : pat_raw;
        s   = (seed_raw == 0) ? 1 : seed_raw;
        ln  = (len_raw > 50) ? 50 : len_raw;
        exp_q.delete();
        exp_ck = 8'h00;
        for (int i = 0; i < 64; i++) begin
            if (i >= pl && i < pl + ln) p = int'(mem_m[i - pl]);
            else                        p = int'(pre_b);
            ks[i] = s;
            exp_q.push_back(8'((p ^ s) & 255));
            exp_ck = exp_ck ^ 8'((p ^ s) & 255);
            par = 0;
            for (int k = 0; k < 5; k++)
                if ((((s >> k) & 1) == 1) && (((taps_tab[sel] >> k) & 1) == 1)) par = par ^ 1;
            s = ((s * 2) % 32) + par;
        end
    endfunction

    task automatic go_idle();
        @(negedge clk);
        msg_wr_en = 1'b0;
        init      = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_msg_str(input string s);
        go_idle();
        for (int i = 0; i < s.len(); i++) begin
            msg_wr_en = 1'b1;
            msg_waddr = 6'(i);
            msg_wdata = s[i];
            mem_m[i]  = s[i];
            @(negedge clk);
        end
        msg_wr_en = 1'b0;
    endtask

    task automatic load_msg_rand();
        go_idle();
        for (int i = 0; i < 64; i++) begin
            msg_wr_en = 1'b1;
            msg_waddr = 6'(i);
            msg_wdata = 8'($urandom_range(0, 255));
            mem_m[i]  = msg_wdata;
            @(negedge clk);
        end
        msg_wr_en = 1'b0;
    endtask

    task automatic start_run(input int pl, input int pat, input int sd, input int ln,
                             input logic [7:0] pb, input bit latch_write);
        @(negedge clk);
        msg_wr_en = 1'b0;
        init      = 1'b1;
        pre_len   = 8'(pl);
        pat_sel   = 3'(pat);
        lfsr_seed = 5'(sd);
        msg_len   = 6'(ln);
        preamble  = pb;
        repeat (2) @(negedge clk);
        init = 1'b0;
        if (latch_write) begin
            msg_wr_en = 1'b1;
            msg_waddr = 6'($urandom_range(0, 63));
            msg_wdata = 8'($urandom_range(0, 255));
            mem_m[msg_waddr] = msg_wdata;
        end
        build_expected(pl, pat, sd, ln, pb);
        @(negedge clk);
        msg_wr_en = 1'b0;
        pre_len   = 8'($urandom_range(0, 255));
        pat_sel   = 3'($urandom_range(0, 7));
        lfsr_seed = 5'($urandom_range(0, 31));
        msg_len   = 6'($urandom_range(0, 63));
        preamble  = 8'($urandom_range(0, 255));
    endtask

    task automatic collect(input bit rnd_ready, input bit junk_writes, input string name);
        int         got, cycles;
        bit         stalled;
        logic [5:0] st_addr;
        logic [7:0] st_data;
        logic [7:0] e;
        got = 0; cycles = 0; stalled = 1'b0; st_addr = '0; st_data = '0;
        while (got < 64 && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (stalled) begin
                vectors++;
                if (enc_valid !== 1'b1 || enc_addr !== st_addr || enc_data !== st_data) begin
                    miscompares++;
                    $display("FAIL %s stall_hold: valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                             name, enc_valid, enc_addr, enc_data, st_addr, st_data);
                end
            end
            enc_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (junk_writes) begin
                msg_wr_en = ($urandom_range(0, 1) == 1);
                msg_waddr = 6'($urandom_range(0, 63));
                msg_wdata = 8'($urandom_range(0, 255));
            end
            stalled = enc_valid && !enc_ready;
            st_addr = enc_addr;
            st_data = enc_data;
            if (enc_valid && enc_ready) begin
                e = exp_q.pop_front();
                vectors++;
                if (enc_data !== e || enc_addr !== 6'(got)) begin
                    miscompares++;
                    $display("FAIL %s beat%0d: addr=%0d data=%h, required addr=%0d data=%h",
                             name, got, enc_addr, enc_data, got, e);
                end
                obs[got] = enc_data;
                got++;
            end
        end
        vectors++;
        if (got < 64) begin
            miscompares++;
            $display("FAIL %s timeout: beats=%0d, required 64", name, got);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || enc_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_entry: done=%b valid=%b, required done=1 valid=0", name, done, enc_valid);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_hold: done=%b, required 1", name, done);
        end
        msg_wr_en = 1'b0;
        enc_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b1; enc_ready = 1'b1; msg_wr_en = 1'b0;
        msg_waddr = '0; msg_wdata = '0; preamble = 8'h7E; pre_len = 8'd9;
        pat_sel = 3'd2; lfsr_seed = 5'd1; msg_len = 6'd24;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (enc_valid !== 1'b0 || enc_addr !== 6'd0 || enc_data !== 8'h00 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b addr=%0d data=%h done=%b, required 0 0 00 0",
                     enc_valid, enc_addr, enc_data, done);
        end
    endtask

    task automatic test_basic();
        logic [7:0] first3 [3];
        int bad;
        first3[0] = 8'h7F; first3[1] = 8'h7D; first3[2] = 8'h78;
        load_msg_str(hey_msg);
        start_run(9, 2, 1, 24, 8'h7E, 1'b0);
        collect(1'b0, 1'b0, "basic");
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs[i] !== first3[i]) begin
                miscompares++;
                $display("FAIL basic_known%0d: got %h, required %h", i, obs[i], first3[i]);
            end
        end
        bad = 0;
        for (int i = 0; i < 24; i++)
            if ((obs[9 + i] ^ 8'(ks[9 + i])) !== hey_msg[i]) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL basic_decrypt: %0d wrong chars, required 0", bad);
        end
    endtask

    task automatic test_backpressure();
        start_run(9, 2, 1, 24, 8'h7E, 1'b0);
        collect(1'b1, 1'b1, "backpressure");
    endtask

    task automatic test_write_drop();
        start_run(9, 2, 1, 24, 8'h7E, 1'b0);
        collect(1'b0, 1'b0, "write_drop");
    endtask

    task automatic test_clamps();
        load_msg_rand();
        start_run(3, 7, 0, 55, 8'h7E, 1'b0);
        collect(1'b1, 1'b0, "clamps");
    endtask

    task automatic test_empty_msg();
        start_run(10, 4, 19, 0, 8'h7E, 1'b0);
        collect(1'b0, 1'b0, "empty_msg");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            load_msg_rand();
            start_run($urandom_range(0, 20), $urandom_range(0, 7), $urandom_range(0, 31),
                      $urandom_range(0, 63), 8'($urandom_range(0, 255)), 1'b1);
            collect(1'b1, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid_run();
        int cycles;
        load_msg_str(hey_msg);
        start_run(9, 2, 1, 24, 8'h7E, 1'b0);
        enc_ready = 1'b1;
        cycles = 0;
        while (!(enc_valid === 1'b1 && enc_addr === 6'd20) && cycles < 500) begin
            @(negedge clk);
            cycles++;
        end
        vectors++;
        if (cycles >= 500) begin
            miscompares++;
            $display("FAIL midrun_reach20: beat 20 never seen, addr=%0d", enc_addr);
        end
        reset = 1'b1;
        init  = 1'b1;
        @(negedge clk);
        vectors++;
        if (enc_valid !== 1'b0 || enc_addr !== 6'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_reset: valid=%b addr=%0d done=%b, required 0 0 0", enc_valid, enc_addr, done);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (enc_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_quiet: valid=%b, required 0", enc_valid);
        end
        start_run(9, 2, 1, 24, 8'h7E, 1'b0);
        collect(1'b0, 1'b0, "after_reset");
        vectors++;
        if (obs[0] !== 8'h7F) begin
            miscompares++;
            $display("FAIL after_reset_first: got %h, required 7f", obs[0]);
        end
    endtask

`ifdef ENC_CKSUM_EN
    task automatic test_cksum();
        start_run(9, 2, 1, 24, 8'h7E, 1'b0);
        collect(1'b1, 1'b0, "cksum_run");
        vectors++;
        if (cksum !== exp_ck) begin
            miscompares++;
            $display("FAIL cksum: got %h, required %h", cksum, exp_ck);
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        hey_msg = "Hey_Hamm_Look_Im_Picasso";
        taps_tab[0] = 'h1E; taps_tab[1] = 'h1D; taps_tab[2] = 'h1B;
        taps_tab[3] = 'h17; taps_tab[4] = 'h14; taps_tab[5] = 'h12;
        test_reset();
        test_basic();
        test_backpressure();
        test_write_drop();
        test_clamps();
        test_empty_msg();
        test_random();
        test_reset_mid_run();
`ifdef ENC_CKSUM_EN
        test_cksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
